mul_issue_pipe: RTL and testbench
=================================

# mul_issue_pipe

Two-stage, valid/ready pipelined wrapper that issues RV32M multiply instructions (MUL, MULH, MULHSU, MULHU) from the EX stage into the combinational multiplier core. It returns the selected 32-bit result with its destination tag towards writeback. It decodes funct3 into the multiplier's sign controls and registers the operands ahead of the multiplier. It also registers the product behind the multiplier, and it supports downstream backpressure and a pipeline flush.

## Interface
Parameters:
- W, 32, operand/result width (only 32 supported)
- TAG_W, 5, destination-register tag width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  upstream has a multiply op
- o_ready  out  1  block accepts op this cycle
- i_funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; 1xx illegal
- i_rs1  in  W  operand x
- i_rs2  in  W  operand y
- i_rd  in  TAG_W  destination tag
- i_flush  in  1  kill all in-flight ops
- o_valid  out  1  result available
- i_ready  in  1  downstream accepts result
- o_result  out  W  selected result half
- o_rd  out  TAG_W  tag of o_result
- o_busy  out  1  any stage occupied

One clock (clk); reset rst_n asynchronous, active-low.

## Operation
- Sign decode, stored in S1 as {x_sign, y_sign}:
  - MUL → 00;
  - MULH → 11;
  - MULHSU → 10 (x signed, y unsigned);
  - MULHU → 00.
- The S1 register also stores a hi_sel flag, which is 0 for MUL and 1 otherwise.
- Illegal funct3 (1xx) is accepted and treated as MUL. Decode is the caller's responsibility; no error is raised.
- Stage S1 holds: s1_valid, rs1, rs2, sign bits, hi_sel, rd.
- The multiplier core is driven combinationally from the S1 registers. It returns hi[W-1:0] and lo[W-1:0] of the 2W-bit product.
- Stage S2 holds: s2_valid, result, rd. On load, result = hi_sel ? hi : lo.
- Advance rules:
  - s2_load = s1_valid && (!s2_valid || i_ready)
  - o_ready = !s1_valid || s2_load
  - accept = i_valid && o_ready && !i_flush
- Register updates, per cycle:
  - S2 takes S1 when s2_load.
  - S2 empties when it is valid, i_ready is high and there is no s2_load.
  - S1 takes the input on accept. S1 clears when s2_load and no accept.
- Flush: i_flush clears s1_valid and s2_valid at the next edge.
  - Flush overrides accept and s2_load in that cycle.
  - o_ready may be high during flush, but the input is dropped.
- Width rules:
  - Signed operands are sign-extended to 2W bits before the multiply.
  - Unsigned operands are zero-extended.
  - The product is 2W bits, with no overflow detection.

## Timing
- Reset values:
  - s1_valid = s2_valid = 0;
  - o_valid = 0;
  - o_result = 0;
  - o_rd = 0;
  - o_busy = 0;
  - o_ready = 1.
- Reset mid-operation discards all ops immediately (asynchronous).
- Latency: op accepted at edge N → o_valid high after edge N+1, with result valid. Depth is 2 registers; o_valid is visible in the cycle following edge N+1.
- Throughput is 1 op/cycle while i_ready is held high.
- Backpressure:
  - With i_ready low, S2 holds and o_result/o_rd are stable.
  - S1 fills, then o_ready drops after at most 1 further accept.
  - o_ready is combinational from i_ready.
- Simultaneous events: in the same cycle, S2 drains (i_ready), S1 moves to S2, and a new op enters S1. This requires no bubble.
- o_valid/o_result must not change while o_valid && !i_ready, unless i_flush or reset.
- o_busy = s1_valid || s2_valid.

## Structure
- The shared defines header carries:
  - the funct3 encodings (MUL/MULH/MULHSU/MULHU);
  - the `MUL_OP width (2);
  - the sign-pair constants.
- The block contains one sub-module, the combinational multiplier core mult_simple, instantiated once between S1 and S2.
- All pipeline registers live in mul_issue_pipe.

## Test plan
- MULHU 0xFFFFFFFF × 0xFFFFFFFF, i_ready=1 → o_valid 2 cycles later, o_result=0xFFFFFFFE.
- MULH 0xFFFFFFFF (-1) × 0x00000002, then MULHSU with the same operands, then MUL with the same operands, back-to-back → results 0xFFFFFFFF, 0xFFFFFFFF, 0xFFFFFFFE on 3 consecutive cycles, with the issued tags in order.
- Stall: issue 3 ops with i_ready=0 → o_ready drops after 2 accepts. o_result is stable for 5 cycles. Releasing i_ready drains all 3 in order, with no duplicates.
- Flush with S1 and S2 full plus i_valid high → next cycle o_valid=0, o_busy=0. The flushed-cycle input does not appear later.
- Assert rst_n low mid-stream, with no clock edge → o_valid=0 and o_result=0 at once. After release, o_ready=1.
- Random signed/unsigned pairs including 0x80000000, 0, 1 and 0x7FFFFFFF, all 4 funct3 values, random i_ready → match a 64-bit reference model.

Source files
------------

// File: rtl/mul_issue_pipe_pkg.sv
// mul_issue_pipe_pkg
// Shared definitions for the RV32M multiply issue pipeline:
//   - funct3 encodings for MUL / MULH / MULHSU / MULHU
//   - MUL_OP: width of the {x_sign, y_sign} control pair
//   - sign-pair constants and the funct3 -> control decode helper
`timescale 1ns/1ps
package mul_issue_pipe_pkg;

  localparam int MUL_OP = 2;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  // {x_sign, y_sign}
  localparam logic [MUL_OP-1:0] SIGN_UU = 2'b00;
  localparam logic [MUL_OP-1:0] SIGN_SU = 2'b10;
  localparam logic [MUL_OP-1:0] SIGN_SS = 2'b11;

  typedef struct packed {
    logic [MUL_OP-1:0] sign;
    logic              hi_sel;
  } mul_ctl_t;

  // Illegal encodings (1xx) fall through to plain MUL; the low half of the
  // product does not depend on operand signedness, so SIGN_UU is exact there.
  function automatic mul_ctl_t mul_decode(input logic [2:0] funct3);
    mul_ctl_t ctl;
    ctl.sign   = SIGN_UU;
    ctl.hi_sel = 1'b0;
    case (funct3)
      F3_MULH:   begin ctl.sign = SIGN_SS; ctl.hi_sel = 1'b1; end
      F3_MULHSU: begin ctl.sign = SIGN_SU; ctl.hi_sel = 1'b1; end
      F3_MULHU:  begin ctl.sign = SIGN_UU; ctl.hi_sel = 1'b1; end
      default:   begin ctl.sign = SIGN_UU; ctl.hi_sel = 1'b0; end
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/mul_issue_pipe_mult_simple.sv
// mult_simple
// Purely combinational W x W multiplier core producing the full 2W-bit
// product split into hi/lo halves.
//   i_x, i_y : operands
//   i_sign   : {x_sign, y_sign}; 1 = treat that operand as two's complement
//   o_hi     : product[2W-1:W]
//   o_lo     : product[W-1:0]
`timescale 1ns/1ps
module mult_simple
  import mul_issue_pipe_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0]      i_x,
  input  logic [W-1:0]      i_y,
  input  logic [MUL_OP-1:0] i_sign,
  output logic [W-1:0]      o_hi,
  output logic [W-1:0]      o_lo
);

  logic [2*W-1:0] x_ext;
  logic [2*W-1:0] y_ext;
  logic [2*W-1:0] prod;

  // Extending each operand to 2W bits by its own signedness makes the low 2W
  // bits of a plain unsigned multiply equal the exact mixed-sign product.
  assign x_ext = {{W{i_sign[1] & i_x[W-1]}}, i_x};
  assign y_ext = {{W{i_sign[0] & i_y[W-1]}}, i_y};
  assign prod  = x_ext * y_ext;

  assign o_hi = prod[2*W-1:W];
  assign o_lo = prod[W-1:0];

endmodule

// File: rtl/mul_issue_pipe.sv
// mul_issue_pipe
// Two-stage valid/ready wrapper issuing RV32M multiplies into mult_simple.
// S1 registers the decoded op and operands; S2 registers the selected half.
//   clk, rst_n          : clock, asynchronous active-low reset
//   i_valid / o_ready   : upstream handshake (o_ready combinational from i_ready)
//   i_funct3            : 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 1xx -> MUL
//   i_rs1, i_rs2, i_rd  : operands and destination tag
//   i_flush             : drop every in-flight op and the current input
//   o_valid / i_ready   : downstream handshake
//   o_result, o_rd      : selected 32-bit result and its tag
//   o_busy              : either stage occupied
`timescale 1ns/1ps
module mul_issue_pipe
  import mul_issue_pipe_pkg::*;
#(
  parameter int W     = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_funct3,
  input  logic [W-1:0]     i_rs1,
  input  logic [W-1:0]     i_rs2,
  input  logic [TAG_W-1:0] i_rd,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [W-1:0]     o_result,
  output logic [TAG_W-1:0] o_rd,
  output logic             o_busy
);

  // S1
  logic              s1_valid_q,  s1_valid_d;
  logic [W-1:0]      s1_rs1_q,    s1_rs1_d;
  logic [W-1:0]      s1_rs2_q,    s1_rs2_d;
  logic [MUL_OP-1:0] s1_sign_q,   s1_sign_d;
  logic              s1_hi_sel_q, s1_hi_sel_d;
  logic [TAG_W-1:0]  s1_rd_q,     s1_rd_d;

  // S2
  logic              s2_valid_q,  s2_valid_d;
  logic [W-1:0]      s2_result_q, s2_result_d;
  logic [TAG_W-1:0]  s2_rd_q,     s2_rd_d;

  logic              s2_load;
  logic              accept;
  mul_ctl_t          dec;
  logic [W-1:0]      mul_hi;
  logic [W-1:0]      mul_lo;

  assign dec = mul_decode(i_funct3);

  mult_simple #(.W(W)) u_mult (
    .i_x    (s1_rs1_q),
    .i_y    (s1_rs2_q),
    .i_sign (s1_sign_q),
    .o_hi   (mul_hi),
    .o_lo   (mul_lo)
  );

  // Handshake: S1 can always hand off when S2 is empty or draining this
  // cycle, which gives full throughput with no bubble.
  always_comb begin
    s2_load = s1_valid_q && (!s2_valid_q || i_ready);
    o_ready = !s1_valid_q || s2_load;
    accept  = i_valid && o_ready && !i_flush;
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_rs1_d    = s1_rs1_q;
    s1_rs2_d    = s1_rs2_q;
    s1_sign_d   = s1_sign_q;
    s1_hi_sel_d = s1_hi_sel_q;
    s1_rd_d     = s1_rd_q;
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_rd_d     = s2_rd_q;

    if (i_flush) begin
      // Payload registers are left as-is; only the valid bits matter.
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid_d  = 1'b1;
        s2_result_d = s1_hi_sel_q ? mul_hi : mul_lo;
        s2_rd_d     = s1_rd_q;
      end else if (s2_valid_q && i_ready) begin
        s2_valid_d  = 1'b0;
      end

      if (accept) begin
        s1_valid_d  = 1'b1;
        s1_rs1_d    = i_rs1;
        s1_rs2_d    = i_rs2;
        s1_sign_d   = dec.sign;
        s1_hi_sel_d = dec.hi_sel;
        s1_rd_d     = i_rd;
      end else if (s2_load) begin
        s1_valid_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_rs1_q    <= '0;
      s1_rs2_q    <= '0;
      s1_sign_q   <= '0;
      s1_hi_sel_q <= 1'b0;
      s1_rd_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_rd_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_rs1_q    <= s1_rs1_d;
      s1_rs2_q    <= s1_rs2_d;
      s1_sign_q   <= s1_sign_d;
      s1_hi_sel_q <= s1_hi_sel_d;
      s1_rd_q     <= s1_rd_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_rd_q     <= s2_rd_d;
    end
  end

  assign o_valid  = s2_valid_q;
  assign o_result = s2_result_q;
  assign o_rd     = s2_rd_q;
  assign o_busy   = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_mul_issue_pipe.sv
`timescale 1ns/1ps
module tb_mul_issue_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [2:0]  i_funct3 = 3'b000;
  logic [31:0] i_rs1 = '0;
  logic [31:0] i_rs2 = '0;
  logic [4:0]  i_rd = '0;
  logic        i_flush = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_result;
  logic [4:0]  o_rd;
  logic        o_busy;

  mul_issue_pipe #(.W(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_funct3(i_funct3), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd),
    .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_rd(o_rd), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;

  logic        smp_valid, smp_ready, smp_busy, smp_acc;
  logic [31:0] smp_result;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h want %h", name, act, exp);
    else n_pass++;
  endtask

  // Independent 64-bit reference using native signed/unsigned arithmetic.
  function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (f3)
      3'b001:  p = sa * sb;
      3'b010:  p = sa * ub;
      3'b011:  p = ua * ub;
      default: p = ua * ub;
    endcase
    if (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011) return p[63:32];
    return p[31:0];
  endfunction

  // One clock cycle: drive at negedge, sample 1ns later, score the handshakes
  // that will happen at the following posedge.
  task automatic cycle(input logic v, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic fl,
                       input logic rdy, input logic [31:0] exp);
    exp_t e;
    @(negedge clk);
    i_valid = v; i_funct3 = f3; i_rs1 = a; i_rs2 = b; i_rd = rd;
    i_flush = fl; i_ready = rdy;
    #1;
    smp_valid = o_valid; smp_ready = o_ready; smp_busy = o_busy;
    smp_result = o_result; smp_acc = v && o_ready && !fl;
    if (o_valid && rdy && !fl) begin
      if (q.size() == 0) begin
        chk("unexpected_output", {27'h0, o_rd, o_result}, 64'h0);
      end else begin
        e = q.pop_front();
        $display("txn rd=%0d result=%h", o_rd, o_result);
        chk("result", {27'h0, o_rd, o_result}, {27'h0, e.rd, e.res});
      end
    end
    if (fl) q.delete();
    else if (smp_acc) begin
      e.res = exp; e.rd = rd;
      q.push_back(e);
    end
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, rdy, 32'h0);
  endtask

  task automatic drain();
    int k = 0;
    do begin
      idle(1'b1);
      k++;
    end while (q.size() != 0 && k < 20);
    idle(1'b1);
    chk("drain_queue_empty", 64'(q.size()), 64'd0);
    chk("drain_not_busy", {63'h0, smp_busy}, 64'd0);
  endtask

  vec_t tbl[14];
  logic [31:0] pool[5];

  initial begin
    int acc_cnt;
    int k;
    logic [2:0]  f3;
    logic [31:0] a, b;

    tbl[0]  = '{3'b001, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
    tbl[1]  = '{3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
    tbl[2]  = '{3'b000, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE};
    tbl[3]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h00000000};
    tbl[4]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000};
    tbl[5]  = '{3'b011, 32'h80000000, 32'h80000000, 32'h40000000};
    tbl[6]  = '{3'b010, 32'h80000000, 32'h80000000, 32'hC0000000};
    tbl[7]  = '{3'b001, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF};
    tbl[8]  = '{3'b000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001};
    tbl[9]  = '{3'b100, 32'h00000003, 32'h00000005, 32'h0000000F};
    tbl[10] = '{3'b111, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE};
    tbl[11] = '{3'b011, 32'hFFFFFFFF, 32'h00000002, 32'h00000001};
    tbl[12] = '{3'b001, 32'h80000000, 32'h00000001, 32'hFFFFFFFF};
    tbl[13] = '{3'b011, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};
    pool[0] = 32'h80000000; pool[1] = 32'h0; pool[2] = 32'h1;
    pool[3] = 32'h7FFFFFFF; pool[4] = 32'hFFFFFFFF;

    // Reset state
    #12;
    chk("rst_o_valid", {63'h0, o_valid}, 64'd0);
    chk("rst_o_result", {32'h0, o_result}, 64'd0);
    chk("rst_o_rd", {59'h0, o_rd}, 64'd0);
    chk("rst_o_busy", {63'h0, o_busy}, 64'd0);
    chk("rst_o_ready", {63'h0, o_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // MULHU latency: accepted at edge N, visible after edge N+1
    cycle(1'b1, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 1'b0, 1'b1, 32'hFFFFFFFE);
    chk("lat_accept", {63'h0, smp_acc}, 64'd1);
    idle(1'b1);
    chk("lat_s1_only_valid", {63'h0, smp_valid}, 64'd0);
    chk("lat_s1_only_busy", {63'h0, smp_busy}, 64'd1);
    idle(1'b1);
    chk("lat_o_valid", {63'h0, smp_valid}, 64'd1);
    drain();

    // Table vectors back-to-back at full throughput
    for (int i = 0; i < 14; i++) begin
      cycle(1'b1, tbl[i].f3, tbl[i].a, tbl[i].b, 5'(i + 1), 1'b0, 1'b1, tbl[i].exp);
      chk("b2b_accept", {63'h0, smp_acc}, 64'd1);
      if (i >= 2) chk("b2b_o_valid", {63'h0, smp_valid}, 64'd1);
    end
    drain();

    // Stall: i_ready low, three ops offered
    acc_cnt = 0;
    cycle(1'b1, 3'b001, 32'hFFFFFFFF, 32'h2, 5'd10, 1'b0, 1'b0, 32'hFFFFFFFF);
    if (smp_acc) acc_cnt++;
    cycle(1'b1, 3'b000, 32'h3, 32'h5, 5'd11, 1'b0, 1'b0, 32'h0000000F);
    if (smp_acc) acc_cnt++;
    cycle(1'b1, 3'b011, 32'hFFFFFFFF, 32'h2, 5'd12, 1'b0, 1'b0, 32'h1);
    if (smp_acc) acc_cnt++;
    chk("stall_accepts", 64'(acc_cnt), 64'd2);
    chk("stall_ready_low", {63'h0, smp_ready}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 3'b011, 32'hFFFFFFFF, 32'h2, 5'd12, 1'b0, 1'b0, 32'h1);
      chk("stall_result_stable", {31'h0, smp_valid, smp_result}, {31'h0, 1'b1, 32'hFFFFFFFF});
    end
    k = 0;
    do begin
      cycle(1'b1, 3'b011, 32'hFFFFFFFF, 32'h2, 5'd12, 1'b0, 1'b1, 32'h1);
      k++;
    end while (!smp_acc && k < 5);
    chk("stall_third_accepted", {63'h0, smp_acc}, 64'd1);
    drain();

    // Flush with both stages full and a new op offered
    cycle(1'b1, 3'b000, 32'h6, 32'h7, 5'd20, 1'b0, 1'b0, 32'd42);
    cycle(1'b1, 3'b000, 32'h8, 32'h9, 5'd21, 1'b0, 1'b0, 32'd72);
    cycle(1'b1, 3'b000, 32'hA, 32'hB, 5'd22, 1'b1, 1'b0, 32'd110);
    idle(1'b1);
    chk("flush_o_valid", {63'h0, smp_valid}, 64'd0);
    chk("flush_o_busy", {63'h0, smp_busy}, 64'd0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("flush_nothing_later", {62'h0, smp_valid, smp_busy}, 64'd0);

    // Asynchronous reset mid-stream, between clock edges
    cycle(1'b1, 3'b000, 32'h1234, 32'h10, 5'd3, 1'b0, 1'b0, 32'h12340);
    cycle(1'b1, 3'b000, 32'h2, 32'h2, 5'd4, 1'b0, 1'b0, 32'h4);
    idle(1'b0);
    chk("pre_rst_result", {32'h0, smp_result}, 64'h12340);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_o_valid", {63'h0, o_valid}, 64'd0);
    chk("async_rst_o_result", {32'h0, o_result}, 64'd0);
    chk("async_rst_o_busy", {63'h0, o_busy}, 64'd0);
    q.delete();
    i_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_o_ready", {63'h0, o_ready}, 64'd1);

    // Random ops against the reference model
    for (int i = 0; i < 300; i++) begin
      f3 = 3'($urandom_range(0, 7));
      k  = int'($urandom_range(0, 7));
      a  = (k < 5) ? pool[k] : $urandom;
      k  = int'($urandom_range(0, 7));
      b  = (k < 5) ? pool[k] : $urandom;
      cycle(1'($urandom_range(0, 3) != 0), f3, a, b, 5'($urandom_range(0, 31)), 1'b0,
            1'($urandom_range(0, 3) != 0), ref_mul(f3, a, b));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
